// File: rtl/lsu_pkg.sv
// Shared types, encodings and helpers for the load/store unit.
// Optional misaligned-access trapping is selected with LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam int LSU_ADDR_W = 13;
  localparam int NUM_LANES  = 4;
  localparam int LANE_W     = 8;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] wdata;
  } lsu_req_t;

  // The reserved size code behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_WORD : size;
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return off;
      SIZE_HALF: return {off[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      default:   return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU-side request/response bus and data-memory strobe bus of the load/store unit.
interface lsu_req_if #(parameter int ADDR_W = lsu_pkg::LSU_ADDR_W);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_misaligned;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned
  );
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned
  );
endinterface

interface lsu_mem_if #(parameter int ADDR_W = lsu_pkg::LSU_ADDR_W);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );
  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_lane_merge.sv
// Combinational byte-lane logic: load extraction with sign/zero extension,
// and store-lane replacement into a previously read word.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [NUM_LANES-1:0]             be;
  logic [NUM_LANES-1:0][LANE_W-1:0] rd_lanes;
  logic [NUM_LANES-1:0][LANE_W-1:0] st_rep;
  logic [NUM_LANES-1:0][LANE_W-1:0] merged;
  logic [31:0]                      shifted;

  assign rd_lanes = rd_word;

  // Store data is replicated across the word so any lane can pick its byte.
  always_comb begin
    be     = 4'hF;
    st_rep = st_data;
    case (size)
      SIZE_BYTE: begin
        be     = 4'b0001 << off;
        st_rep = {4{st_data[7:0]}};
      end
      SIZE_HALF: begin
        be     = 4'b0011 << off;
        st_rep = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign merged[i] = be[i] ? st_rep[i] : rd_lanes[i];
  end

  assign st_word = merged;
  assign shifted = rd_word >> {off, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (size)
      SIZE_BYTE: ld_data = {{24{~uns & shifted[7]}},  shifted[7:0]};
      SIZE_HALF: ld_data = {{16{~uns & shifted[15]}}, shifted[15:0]};
      default:   ld_data = rd_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: byte/half/word accesses to a word memory, with
// sub-word stores done as read-modify-write. Option: LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W
) (
  input  logic      clock,
  input  logic      reset_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  lsu_state_t        state, nxt;
  lsu_req_t          rq_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       rdata_q;
  logic              mis_q;

  logic        accept;
  logic [1:0]  size_n;
  logic        mis_n;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  assign accept = req.req_valid && (state == ST_IDLE);
  assign size_n = norm_size(req.req_size);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_n = is_misaligned(size_n, req.req_addr[1:0]);
`else
  assign mis_n = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (req.req_valid) begin
        if (mis_n)                                       nxt = ST_RESP;
        else if (req.req_write && size_n == SIZE_WORD)   nxt = ST_WR;
        else                                             nxt = ST_RD;
      end
      ST_RD:   nxt = rq_q.write ? ST_WR : ST_RESP;
      ST_WR:   nxt = ST_RESP;
      ST_RESP: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Offending offset bits are dropped at capture; when trapping is enabled a
  // misaligned access never touches memory so the masked offset is unused.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      rq_q    <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q     <= req.req_addr[ADDR_W+1:2];
        rq_q.write <= req.req_write;
        rq_q.size  <= size_n;
        rq_q.uns   <= req.req_unsigned;
        rq_q.off   <= align_off(size_n, req.req_addr[1:0]);
        rq_q.wdata <= req.req_wdata;
        mis_q      <= mis_n;
      end
      if (state == ST_RD) rdata_q <= mem.mem_rdata;
    end
  end

  lsu_lane_merge u_merge (
    .rd_word (rdata_q),
    .st_data (rq_q.wdata),
    .size    (rq_q.size),
    .off     (rq_q.off),
    .uns     (rq_q.uns),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    req.req_ready       = (state == ST_IDLE);
    mem.mem_read        = (state == ST_RD);
    mem.mem_write       = (state == ST_WR);
    mem.mem_addr        = addr_q;
    mem.mem_wdata       = (state == ST_WR) ? st_word : 32'h0;
    req.resp_valid      = (state == ST_RESP);
    req.resp_misaligned = (state == ST_RESP) && mis_q;
    req.resp_rdata      = ((state == ST_RESP) && !rq_q.write && !mis_q) ? ld_data : 32'h0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses,
// a negedge monitor pops and compares; a small behavioural memory sits on the strobes.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clock;
  logic reset_n;

  lsu_req_if #(.ADDR_W(13)) rq ();
  lsu_mem_if #(.ADDR_W(13)) mb ();

  load_store_unit #(.ADDR_W(13)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (rq),
    .mem     (mb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   resp_cnt = 0;
  int   issued   = 0;

  logic [31:0] mem [0:15];

  // Memory updates read data / storage on the falling edge of the strobe cycle.
  always @(negedge clock) begin
    if (mb.mem_read)  mb.mem_rdata <= mem[mb.mem_addr[3:0]];
    if (mb.mem_write) mem[mb.mem_addr[3:0]] <= mb.mem_wdata;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clock) begin
    if (reset_n) begin
      if (mb.mem_read && mb.mem_write) begin
        errors++;
        $display("FAIL strobe_overlap: got both strobes expected at most one");
      end
      if (rq.resp_valid) begin
        resp_cnt++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got resp_valid expected none");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_rdata", rq.resp_rdata, e.rdata);
          chk("resp_misaligned", {31'b0, rq.resp_misaligned}, {31'b0, e.mis});
        end
      end
    end
  end

  // Issue one request from IDLE and check latency, strobe pattern, address, write data.
  task automatic do_req(input string name, input logic wr, input logic [1:0] size, input logic uns,
                        input logic [14:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_mis, input int exp_lat,
                        input logic [7:0] exp_rd, input logic [7:0] exp_wr, input logic [31:0] exp_wd);
    int          lat;
    logic [7:0]  rdm, wrm;
    logic [31:0] wd;
    logic [12:0] ma;
    exp_t        e;
    @(negedge clock);
    chk({name, "_ready"}, {31'b0, rq.req_ready}, 32'd1);
    rq.req_valid = 1'b1; rq.req_write = wr; rq.req_size = size;
    rq.req_unsigned = uns; rq.req_addr = addr; rq.req_wdata = wdata;
    e.rdata = exp_rdata; e.mis = exp_mis;
    sb.push_back(e);
    issued++;
    @(posedge clock);
    lat = 0; rdm = '0; wrm = '0; wd = '0; ma = '0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clock);
      rq.req_valid = 1'b0;
      if (mb.mem_read)  rdm[c] = 1'b1;
      if (mb.mem_write) begin wrm[c] = 1'b1; wd = mb.mem_wdata; end
      if (mb.mem_read || mb.mem_write) ma = mb.mem_addr;
      if (rq.resp_valid) lat = c;
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_rd_cycles"}, {24'b0, rdm}, {24'b0, exp_rd});
    chk({name, "_wr_cycles"}, {24'b0, wrm}, {24'b0, exp_wr});
    if (exp_wr != 0) chk({name, "_mem_wdata"}, wd, exp_wd);
    if ((exp_rd | exp_wr) != 0) chk({name, "_mem_addr"}, {19'b0, ma}, 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first, second, accepts, rc0;
    rq.req_valid = 1'b0; rq.req_write = 1'b0; rq.req_size = 2'b00;
    rq.req_unsigned = 1'b0; rq.req_addr = '0; rq.req_wdata = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", {31'b0, rq.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, rq.resp_valid}, 32'd0);
    chk("rst_resp_mis", {31'b0, rq.resp_misaligned}, 32'd0);
    chk("rst_resp_rdata", rq.resp_rdata, 32'd0);
    chk("rst_strobes", {30'b0, mb.mem_read, mb.mem_write}, 32'd0);
    chk("rst_mem_addr", {19'b0, mb.mem_addr}, 32'd0);
    chk("rst_mem_wdata", mb.mem_wdata, 32'd0);
    reset_n = 1'b1;

    //      name      wr   size   uns  addr      wdata          exp_rdata     mis lat rd     wr     wdata
    do_req("st_w",    1, 2'b10, 0, 15'h0010, 32'hDEADBEEF, 32'h00000000, 0, 2, 8'h00, 8'h02, 32'hDEADBEEF);
    do_req("ld_w",    0, 2'b10, 0, 15'h0010, 32'h0,        32'hDEADBEEF, 0, 2, 8'h02, 8'h00, 32'h0);
    do_req("st_w2",   1, 2'b10, 0, 15'h0010, 32'h11223344, 32'h00000000, 0, 2, 8'h00, 8'h02, 32'h11223344);
    do_req("st_b",    1, 2'b00, 0, 15'h0012, 32'h123456AA, 32'h00000000, 0, 3, 8'h02, 8'h04, 32'h11AA3344);
    do_req("ld_rmw",  0, 2'b10, 0, 15'h0010, 32'h0,        32'h11AA3344, 0, 2, 8'h02, 8'h00, 32'h0);
    do_req("st_h",    1, 2'b01, 0, 15'h0012, 32'h0000BEEF, 32'h00000000, 0, 3, 8'h02, 8'h04, 32'hBEEF3344);
    do_req("st_w3",   1, 2'b10, 0, 15'h0010, 32'h80FF7F01, 32'h00000000, 0, 2, 8'h00, 8'h02, 32'h80FF7F01);
    do_req("ld_sb1",  0, 2'b00, 0, 15'h0011, 32'h0,        32'h0000007F, 0, 2, 8'h02, 8'h00, 32'h0);
    do_req("ld_ub2",  0, 2'b00, 1, 15'h0012, 32'h0,        32'h000000FF, 0, 2, 8'h02, 8'h00, 32'h0);
    do_req("ld_sh2",  0, 2'b01, 0, 15'h0012, 32'h0,        32'hFFFF80FF, 0, 2, 8'h02, 8'h00, 32'h0);
    do_req("ld_sb3",  0, 2'b00, 0, 15'h0013, 32'h0,        32'hFFFFFF80, 0, 2, 8'h02, 8'h00, 32'h0);
    do_req("ld_sb2",  0, 2'b00, 0, 15'h0012, 32'h0,        32'hFFFFFFFF, 0, 2, 8'h02, 8'h00, 32'h0);
    do_req("ld_uh0",  0, 2'b01, 1, 15'h0010, 32'h0,        32'h00007F01, 0, 2, 8'h02, 8'h00, 32'h0);
    do_req("ld_rsvd", 0, 2'b11, 0, 15'h0010, 32'h0,        32'h80FF7F01, 0, 2, 8'h02, 8'h00, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    do_req("mis_w",   0, 2'b10, 0, 15'h0013, 32'h0,        32'h00000000, 1, 1, 8'h00, 8'h00, 32'h0);
    do_req("mis_h",   0, 2'b01, 0, 15'h0011, 32'h0,        32'h00000000, 1, 1, 8'h00, 8'h00, 32'h0);
    do_req("mis_st",  1, 2'b10, 0, 15'h0011, 32'h0BADF00D, 32'h00000000, 1, 1, 8'h00, 8'h00, 32'h0);
`else
    do_req("mis_w",   0, 2'b10, 0, 15'h0013, 32'h0,        32'h80FF7F01, 0, 2, 8'h02, 8'h00, 32'h0);
    do_req("mis_h",   0, 2'b01, 0, 15'h0011, 32'h0,        32'h00007F01, 0, 2, 8'h02, 8'h00, 32'h0);
`endif

    // Reset pulse during the RD cycle of a byte store must abandon it.
    @(negedge clock);
    rq.req_valid = 1'b1; rq.req_write = 1'b1; rq.req_size = 2'b00;
    rq.req_unsigned = 1'b0; rq.req_addr = 15'h0012; rq.req_wdata = 32'h00000055;
    @(posedge clock);
    @(negedge clock);
    rq.req_valid = 1'b0;
    chk("rstmid_rd_active", {31'b0, mb.mem_read}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rstmid_strobes_drop", {30'b0, mb.mem_read, mb.mem_write}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rstmid_ready", {31'b0, rq.req_ready}, 32'd1);
    chk("rstmid_resp_valid", {31'b0, rq.resp_valid}, 32'd0);
    chk("rstmid_mem_word", mem[4], 32'h80FF7F01);
    do_req("ld_after_rst", 0, 2'b10, 0, 15'h0010, 32'h0, 32'h80FF7F01, 0, 2, 8'h02, 8'h00, 32'h0);

    // Held request: accepted only in IDLE, so twice over six edges, 3 cycles apart.
    @(negedge clock);
    rc0 = resp_cnt;
    first = -1; second = -1; accepts = 0;
    rq.req_valid = 1'b1; rq.req_write = 1'b0; rq.req_size = 2'b10;
    rq.req_unsigned = 1'b0; rq.req_addr = 15'h0010;
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e.rdata = 32'h80FF7F01; e.mis = 1'b0;
      sb.push_back(e);
      issued++;
    end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clock);
      if (rq.req_ready) begin
        accepts++;
        if (first < 0) first = k; else second = k;
      end
      @(posedge clock);
    end
    @(negedge clock);
    rq.req_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk("held_accepts", accepts, 32'd2);
    chk("held_spacing", second - first, 32'd3);
    chk("held_resp_count", resp_cnt - rc0, 32'd2);

    chk("sb_drained", sb.size(), 32'd0);
    chk("total_resp", resp_cnt, issued);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
